adc_frame_ctrl: RTL

Sequencing controller for the ADC sampling path. It generates the programmable `sample_clk` that drives the ADC sampler and captures the sampler's 12-bit output at a fixed, safe offset after each sample edge. On request it records a frame of `FRAME_LEN` consecutive samples into an external sample buffer, either immediately or after a threshold-crossing trigger. It sits between the ADC sampler and the frame buffer / DSP consumer.

---
 rtl/adc_pkg.sv | 8 +
 rtl/adc_clk_div.sv | 45 ++++
 rtl/adc_frame_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC frame capture path.
package adc_pkg;
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} adc_state_t;
  typedef enum logic {TRIG_IMMEDIATE = 1'b0, TRIG_RISING = 1'b1} trig_mode_t;
  localparam int ADC_SAMPLE_W = 12;
  localparam int MIN_DIV      = 3;
  localparam int CAP_DELAY    = 2;
endpackage

// File: rtl/adc_clk_div.sv
// Free-running sample clock divider: period P+1 clk cycles, high for (P+1)>>1,
// with a one-cycle pulse on the first high cycle of each period.
module adc_clk_div
  import adc_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             sample_clk,
  output logic             sclk_edge
);
  logic [DIV_W-1:0] cnt_q, cnt_d, per_q, per_d, cfg_clamp;
  logic [DIV_W:0]   half;
  logic             wrap, sample_clk_q, sample_clk_d, edge_q, edge_d;

  always_comb begin
    cfg_clamp    = (cfg_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_div;
    half         = ({1'b0, per_q} + (DIV_W+1)'(1)) >> 1;
    wrap         = (cnt_q == per_q);
    cnt_d        = wrap ? '0 : cnt_q + DIV_W'(1);
    // The period is only reloaded at wrap so a config change never truncates a period.
    per_d        = wrap ? cfg_clamp : per_q;
    sample_clk_d = ({1'b0, cnt_q} < half);
    edge_d       = (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      per_q        <= cfg_clamp;
      sample_clk_q <= 1'b0;
      edge_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      sample_clk_q <= sample_clk_d;
      edge_q       <= edge_d;
    end
  end

  assign sample_clk = sample_clk_q;
  assign sclk_edge  = edge_q;
endmodule

// File: rtl/adc_frame_ctrl.sv
// ADC frame controller: drives the sampler clock, captures samples a fixed
// delay after each sample edge, and writes immediate or triggered frames.
module adc_frame_ctrl
  import adc_pkg::*;
#(
  parameter int SAMPLE_W  = ADC_SAMPLE_W,
  parameter int FRAME_LEN = 256,
  parameter int DIV_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DIV_W-1:0]             cfg_div,
  input  logic                         trig_mode,
  input  logic [SAMPLE_W-1:0]          trig_level,
  input  logic                         start,
  input  logic                         abort,
  input  logic [SAMPLE_W-1:0]          sample_in,
  output logic                         sample_clk,
  output logic                         wr_en,
  output logic [$clog2(FRAME_LEN)-1:0] wr_addr,
  output logic [SAMPLE_W-1:0]          wr_data,
  output logic                         busy,
  output logic                         armed,
  output logic                         frame_done
);
  localparam int AW = $clog2(FRAME_LEN);

  logic                 sclk_edge, cap_stb, trig_hit;
  logic [CAP_DELAY-1:0] stb_pipe_q, stb_pipe_d;
  adc_state_t           state_q;
  logic [AW-1:0]        addr_q, wr_addr_q;
  logic [SAMPLE_W-1:0]  wr_data_q, prev_q;
  logic                 prev_vld_q, wr_en_q, frame_done_q;

  adc_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .cfg_div   (cfg_div),
    .sample_clk(sample_clk),
    .sclk_edge (sclk_edge)
  );

  // Delay the edge so sample_in is taken once the sampler output has settled.
  always_comb begin
    stb_pipe_d = CAP_DELAY'({stb_pipe_q, sclk_edge});
    cap_stb    = stb_pipe_q[CAP_DELAY-1];
    trig_hit   = prev_vld_q && (prev_q < trig_level) && (sample_in >= trig_level);
  end

  always_ff @(posedge clk) begin
    if (rst) stb_pipe_q <= '0;
    else     stb_pipe_q <= stb_pipe_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (abort && state_q != IDLE) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (start && !abort) begin
            state_q    <= (trig_mode_t'(trig_mode) == TRIG_RISING) ? ARM : CAPTURE;
            addr_q     <= '0;
            prev_vld_q <= 1'b0;
          end
          ARM: if (cap_stb) begin
            prev_q     <= sample_in;
            prev_vld_q <= 1'b1;
            if (trig_hit) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= '0;
              wr_data_q <= sample_in;
              addr_q    <= AW'(1);
              state_q   <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (cap_stb) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= sample_in;
              addr_q    <= addr_q + AW'(1);
            end else if (wr_en_q && wr_addr_q == AW'(FRAME_LEN-1)) begin
              // Last write is on the bus this cycle; pulse done on the next.
              state_q      <= DONE;
              frame_done_q <= 1'b1;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Abort also cancels a write or done pulse already registered for this cycle.
  assign wr_en      = wr_en_q & ~abort;
  assign frame_done = frame_done_q & ~abort;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != IDLE);
  assign armed      = (state_q == ARM);
endmodule
